// File: rtl/fx_regbank.sv
// fx_regbank: device-selected register bank with shadowed config,
// commit/auto-commit, sticky W1C status and masked interrupt.
module fx_regbank #(
   parameter int          N_CFG    = 8,
   parameter logic [15:0] CFG_BASE = 16'h0080,
   parameter logic [N_CFG*8-1:0] CFG_RST = '0,
   parameter logic [7:0]  VERSION  = 8'h02
) (
   input  logic               clk_sys,
   input  logic               rst_n,
   input  logic [5:0]         dev_id,
   input  logic               fx_wr,
   input  logic [21:0]        fx_waddr,
   input  logic [7:0]         fx_data,
   input  logic               fx_rd,
   input  logic [21:0]        fx_raddr,
   output logic [7:0]         fx_q,
   input  logic               sync_in,
   input  logic [7:0]         stat_evt,
   output logic [7:0]         cfg_path_sel,
   output logic [N_CFG*8-1:0] cfg_active,
   output logic               cfg_upd,
   output logic               irq
);

   localparam logic [15:0] A_ID   = 16'h0000;
   localparam logic [15:0] A_VER  = 16'h0001;
   localparam logic [15:0] A_STAT = 16'h0010;
   localparam logic [15:0] A_MASK = 16'h0011;
   localparam logic [15:0] A_CTRL = 16'h0012;
   localparam logic [15:0] A_PATH = 16'h0020;
   localparam logic [15:0] N_CFG16 = 16'(N_CFG);

   // The config window must sit above the fixed map and fit the bank size.
   if (CFG_BASE <= A_PATH) begin : g_bad_base
      $error("fx_regbank: CFG_BASE overlaps fixed registers");
   end
   if (N_CFG < 1 || N_CFG > 32) begin : g_bad_ncfg
      $error("fx_regbank: N_CFG out of range 1..32");
   end

   logic [7:0]         fx_q_q, fx_q_d;
   logic [7:0]         path_q, path_d;
   logic [7:0]         stat_q, stat_d;
   logic [7:0]         mask_q, mask_d;
   logic               auto_q, auto_d;
   logic               pend_q, pend_d;
   logic               upd_q, upd_d;
   logic               irq_q, irq_d;
   logic [N_CFG*8-1:0] shadow_q, shadow_d;
   logic [N_CFG*8-1:0] active_q, active_d;

   logic        wr_sel, rd_sel, w_cfg, commit;
   logic [15:0] wa, ra, w_off, r_off;
   logic [7:0]  rdata, w1c;

   // Address decode and read-data mux (reads see pre-write state).
   always_comb begin
      wr_sel = fx_wr && (fx_waddr[21:16] == dev_id);
      rd_sel = fx_rd && (fx_raddr[21:16] == dev_id);
      wa     = fx_waddr[15:0];
      ra     = fx_raddr[15:0];
      w_off  = wa - CFG_BASE;
      r_off  = ra - CFG_BASE;
      w_cfg  = wr_sel && (w_off < N_CFG16);
      rdata  = 8'h00;
      case (ra)
         A_ID:    rdata = {2'b00, dev_id};
         A_VER:   rdata = VERSION;
         A_STAT:  rdata = stat_q;
         A_MASK:  rdata = mask_q;
         A_CTRL:  rdata = {6'b0, auto_q, 1'b0};
         A_PATH:  rdata = path_q;
         default: begin
            for (int k = 0; k < N_CFG; k++) begin
               if (r_off == 16'(k)) rdata = shadow_q[k*8 +: 8];
            end
         end
      endcase
      fx_q_d = rd_sel ? rdata : 8'h00;
   end

   // Next-state for registers, shadow/commit and status/interrupt.
   always_comb begin
      commit = (wr_sel && wa == A_CTRL && fx_data[0]) ||
               (sync_in && auto_q && pend_q);
      path_d   = path_q;
      mask_d   = mask_q;
      auto_d   = auto_q;
      shadow_d = shadow_q;
      active_d = commit ? shadow_q : active_q;
      upd_d    = commit;
      w1c      = (wr_sel && wa == A_STAT) ? fx_data : 8'h00;
      stat_d   = (stat_q & ~w1c) | stat_evt;
      irq_d    = |(stat_q & mask_q);
      pend_d   = w_cfg ? 1'b1 : (commit ? 1'b0 : pend_q);
      if (wr_sel && wa == A_MASK) mask_d = fx_data;
      if (wr_sel && wa == A_CTRL) auto_d = fx_data[1];
      if (wr_sel && wa == A_PATH) path_d = fx_data;
      if (w_cfg) begin
         for (int k = 0; k < N_CFG; k++) begin
            if (w_off == 16'(k)) shadow_d[k*8 +: 8] = fx_data;
         end
      end
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         fx_q_q   <= 8'h00;
         path_q   <= 8'h00;
         stat_q   <= 8'h00;
         mask_q   <= 8'h00;
         auto_q   <= 1'b0;
         pend_q   <= 1'b0;
         upd_q    <= 1'b0;
         irq_q    <= 1'b0;
         shadow_q <= CFG_RST;
         active_q <= CFG_RST;
      end else begin
         fx_q_q   <= fx_q_d;
         path_q   <= path_d;
         stat_q   <= stat_d;
         mask_q   <= mask_d;
         auto_q   <= auto_d;
         pend_q   <= pend_d;
         upd_q    <= upd_d;
         irq_q    <= irq_d;
         shadow_q <= shadow_d;
         active_q <= active_d;
      end
   end

   assign fx_q         = fx_q_q;
   assign cfg_path_sel = path_q;
   assign cfg_active   = active_q;
   assign cfg_upd      = upd_q;
   assign irq          = irq_q;

endmodule

// File: tb/tb_fx_regbank.sv
// tb_fx_regbank: scoreboard bench with a transaction-level reference
// model; stimulus pushes expectations, a monitor pops and compares.
module tb_fx_regbank;

   localparam int          N    = 8;
   localparam logic [15:0] BASE = 16'h0080;
   localparam logic [N*8-1:0] RSTV = 64'h8877_6655_4433_2211;
   localparam logic [7:0]  VER  = 8'h02;
   localparam logic [5:0]  DEV  = 6'h05;

   logic          clk_sys = 1'b0;
   logic          rst_n;
   logic [5:0]    dev_id;
   logic          fx_wr, fx_rd, sync_in;
   logic [21:0]   fx_waddr, fx_raddr;
   logic [7:0]    fx_data, fx_q, stat_evt, cfg_path_sel;
   logic [N*8-1:0] cfg_active;
   logic          cfg_upd, irq;

   fx_regbank #(
      .N_CFG(N), .CFG_BASE(BASE), .CFG_RST(RSTV), .VERSION(VER)
   ) dut (
      .clk_sys(clk_sys), .rst_n(rst_n), .dev_id(dev_id),
      .fx_wr(fx_wr), .fx_waddr(fx_waddr), .fx_data(fx_data),
      .fx_rd(fx_rd), .fx_raddr(fx_raddr), .fx_q(fx_q),
      .sync_in(sync_in), .stat_evt(stat_evt),
      .cfg_path_sel(cfg_path_sel), .cfg_active(cfg_active),
      .cfg_upd(cfg_upd), .irq(irq)
   );

   always #5 clk_sys = ~clk_sys;

   typedef struct packed {
      logic [7:0]     q;
      logic           upd;
      logic           irq;
      logic [7:0]     path;
      logic [N*8-1:0] act;
   } exp_t;

   exp_t sbq[$];
   int errors = 0;
   int checks = 0;

   logic [7:0] m_sh [N];
   logic [7:0] m_act [N];
   logic [7:0] m_path, m_stat, m_mask;
   bit         m_auto, m_pend;

   function automatic logic [7:0] m_read(input logic [15:0] a);
      if (a == 16'h0000) return {2'b00, DEV};
      if (a == 16'h0001) return VER;
      if (a == 16'h0010) return m_stat;
      if (a == 16'h0011) return m_mask;
      if (a == 16'h0012) return {6'b0, m_auto, 1'b0};
      if (a == 16'h0020) return m_path;
      if (a >= BASE && 32'(a) < 32'(BASE) + N) return m_sh[a - BASE];
      return 8'h00;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < N; k++) begin
         m_sh[k]  = RSTV[k*8 +: 8];
         m_act[k] = RSTV[k*8 +: 8];
      end
      m_path = 0; m_stat = 0; m_mask = 0;
      m_auto = 0; m_pend = 0;
   endtask

   // One clock of stimulus; model predicts outputs after the next edge.
   task automatic cyc(input bit r, input bit wr, input logic [21:0] wad,
                      input logic [7:0] d, input bit rd,
                      input logic [21:0] rad, input bit sy,
                      input logic [7:0] ev);
      exp_t e;
      bit ws, rs, cm;
      logic [15:0] a;
      @(negedge clk_sys);
      rst_n = !r; fx_wr = wr; fx_waddr = wad; fx_data = d;
      fx_rd = rd; fx_raddr = rad; sync_in = sy; stat_evt = ev;
      e = '0;
      if (r) begin
         model_reset();
      end else begin
         ws = wr && wad[21:16] == DEV;
         rs = rd && rad[21:16] == DEV;
         a  = wad[15:0];
         e.q   = rs ? m_read(rad[15:0]) : 8'h00;
         e.irq = |(m_stat & m_mask);
         cm = (ws && a == 16'h0012 && d[0]) || (sy && m_auto && m_pend);
         e.upd = cm;
         if (cm) begin
            m_act  = m_sh;
            m_pend = 0;
         end
         m_stat = (m_stat & ~((ws && a == 16'h0010) ? d : 8'h00)) | ev;
         if (ws) begin
            if (a == 16'h0011) m_mask = d;
            else if (a == 16'h0012) m_auto = d[1];
            else if (a == 16'h0020) m_path = d;
            else if (a >= BASE && 32'(a) < 32'(BASE) + N) begin
               m_sh[a - BASE] = d;
               m_pend = 1;
            end
         end
      end
      e.path = m_path;
      for (int k = 0; k < N; k++) e.act[k*8 +: 8] = m_act[k];
      sbq.push_back(e);
   endtask

   task automatic idle();
      cyc(0, 0, 22'h0, 8'h00, 0, 22'h0, 0, 8'h00);
   endtask

   task automatic wr(input logic [15:0] a, input logic [7:0] d);
      cyc(0, 1, {DEV, a}, d, 0, 22'h0, 0, 8'h00);
   endtask

   task automatic rd(input logic [15:0] a);
      cyc(0, 0, 22'h0, 8'h00, 1, {DEV, a}, 0, 8'h00);
   endtask

   task automatic chk(input string n, input logic [63:0] act,
                      input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h at %0t", n, act, req,
                  $time);
      end
   endtask

   // Monitor: one expected record per clock, sampled just after the edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk_sys);
         #1;
         if (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk("fx_q", 64'(fx_q), 64'(e.q));
            chk("cfg_upd", 64'(cfg_upd), 64'(e.upd));
            chk("irq", 64'(irq), 64'(e.irq));
            chk("cfg_path_sel", 64'(cfg_path_sel), 64'(e.path));
            chk("cfg_active", 64'(cfg_active), 64'(e.act));
         end
      end
   end

   function automatic logic [15:0] pick_addr();
      case ($urandom_range(0, 11))
         0:       return 16'h0000;
         1:       return 16'h0001;
         2, 3:    return 16'h0010;
         4:       return 16'h0011;
         5, 6:    return 16'h0012;
         7:       return 16'h0020;
         8:       return 16'h0050;
         9:       return BASE + 16'(N);
         default: return BASE + 16'($urandom_range(0, N - 1));
      endcase
   endfunction

   initial begin
      logic [5:0] wd, rdv;
      rst_n = 0; dev_id = DEV;
      fx_wr = 0; fx_waddr = 0; fx_data = 0;
      fx_rd = 0; fx_raddr = 0; sync_in = 0; stat_evt = 0;
      model_reset();
      cyc(1, 0, 22'h0, 8'h00, 0, 22'h0, 0, 8'h00);
      cyc(1, 0, 22'h0, 8'h00, 0, 22'h0, 0, 8'h00);
      // ID, config reset value read, shadow/commit
      rd(16'h0000);
      rd(16'h0084);
      rd(16'h0001);
      wr(16'h0082, 8'hA5);
      rd(16'h0082);
      wr(16'h0012, 8'h01);
      idle();
      wr(16'h0012, 8'h01);
      idle();
      // auto-commit on sync, then sync with nothing pending
      wr(16'h0012, 8'h02);
      wr(16'h0080, 8'h3C);
      cyc(0, 0, 22'h0, 8'h00, 0, 22'h0, 1, 8'h00);
      idle();
      cyc(0, 0, 22'h0, 8'h00, 0, 22'h0, 1, 8'h00);
      idle();
      // shadow write in the commit cycle stays pending
      cyc(0, 1, {DEV, 16'h0081}, 8'h11, 0, 22'h0, 1, 8'h00);
      cyc(0, 1, {DEV, 16'h0081}, 8'h22, 0, 22'h0, 1, 8'h00);
      cyc(0, 0, 22'h0, 8'h00, 0, 22'h0, 1, 8'h00);
      idle();
      // sticky status, set-wins, irq
      wr(16'h0011, 8'h04);
      cyc(0, 0, 22'h0, 8'h00, 0, 22'h0, 0, 8'h04);
      idle();
      cyc(0, 1, {DEV, 16'h0010}, 8'h04, 0, 22'h0, 0, 8'h04);
      rd(16'h0010);
      wr(16'h0010, 8'h04);
      idle();
      rd(16'h0010);
      // foreign device, unmapped and RO accesses, same-cycle rd/wr
      cyc(0, 1, {6'h06, 16'h0020}, 8'hFF, 0, 22'h0, 0, 8'h00);
      cyc(0, 0, 22'h0, 8'h00, 1, {6'h06, 16'h0000}, 0, 8'h00);
      rd(16'h0050);
      wr(16'h0001, 8'hEE);
      wr(16'h0050, 8'hEE);
      rd(16'h0020);
      cyc(0, 1, {DEV, 16'h0020}, 8'h77, 1, {DEV, 16'h0020}, 0, 8'h00);
      rd(16'h0020);
      // reset asserted during a commit write
      wr(16'h0083, 8'h99);
      cyc(1, 1, {DEV, 16'h0012}, 8'h01, 0, 22'h0, 0, 8'h00);
      cyc(1, 0, 22'h0, 8'h00, 0, 22'h0, 0, 8'h00);
      idle();
      idle();
      rd(16'h0083);
      // randomized traffic
      for (int i = 0; i < 600; i++) begin
         wd  = ($urandom_range(0, 7) == 0) ? 6'($urandom) : DEV;
         rdv = ($urandom_range(0, 7) == 0) ? 6'($urandom) : DEV;
         cyc($urandom_range(0, 149) == 0,
             $urandom_range(0, 1) == 1, {wd, pick_addr()},
             8'($urandom),
             $urandom_range(0, 1) == 1, {rdv, pick_addr()},
             $urandom_range(0, 3) == 0,
             8'($urandom & $urandom & $urandom));
      end
      idle();
      repeat (10) begin
         if (sbq.size() == 0) break;
         @(posedge clk_sys);
         #2;
      end
      if (sbq.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain actual=%0d required=0 pending records",
                  sbq.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
